// File: rtl/ex_writeback_fwd.sv
// MEM/WB pipeline registers with register-file writeback, operand forwarding and load-use stall.
// Define EXWB_FORWARD_EN to enable forwarding; otherwise hazards are resolved by stalling only.
module ex_writeback_fwd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_wnum,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        flush_mem,
    input  logic [31:0] mem_rdata,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    output logic        wb_we,
    output logic [4:0]  wb_num,
    output logic [31:0] wb_data,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [31:0] fwd_a_data,
    output logic [31:0] fwd_b_data,
    output logic        stall
);

    logic        mem_valid;
    logic        mem_regwrite;
    logic        mem_memread;
    logic [4:0]  mem_wnum;
    logic [31:0] mem_result;
    logic        wb_valid;
    logic        wb_regwrite;

    // EX -> MEM -> WB; neither stage is ever held by stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_wnum     <= 5'd0;
            mem_result   <= 32'd0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_num       <= 5'd0;
            wb_data      <= 32'd0;
        end else begin
            mem_valid    <= ex_valid & ~flush_mem;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_wnum     <= ex_wnum;
            mem_result   <= ex_result;
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_num       <= mem_wnum;
            wb_data      <= mem_memread ? mem_rdata : mem_result;
        end
    end

    assign wb_we = wb_valid & wb_regwrite & (wb_num != 5'd0);

`ifdef EXWB_FORWARD_EN
    // A load in MEM has no data yet, so it is never a forwarding source
    function automatic logic [1:0] pick_src(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0) begin
            if (mem_valid && mem_regwrite && !mem_memread && mem_wnum == src)
                sel = 2'b01;
            else if (wb_valid && wb_regwrite && wb_num == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    function automatic logic [31:0] pick_data(input logic [1:0] sel);
        logic [31:0] val;
        case (sel)
            2'b01:   val = mem_result;
            2'b10:   val = wb_data;
            default: val = 32'd0;
        endcase
        return val;
    endfunction

    always_comb begin
        fwd_a_sel  = pick_src(ex_rs);
        fwd_b_sel  = pick_src(ex_rt);
        fwd_a_data = pick_data(fwd_a_sel);
        fwd_b_data = pick_data(fwd_b_sel);
        stall      = ex_valid & ex_memread & ex_regwrite & (ex_wnum != 5'd0) &
                     ((ex_wnum == id_rs) | (ex_wnum == id_rt));
    end
`else
    logic ex_hit;
    logic mem_hit;
    logic unused_srcs;

    // Without forwarding, ID waits until the producer reaches WB (write-before-read)
    always_comb begin
        ex_hit     = ex_valid & ex_regwrite & (ex_wnum != 5'd0) &
                     ((ex_wnum == id_rs) | (ex_wnum == id_rt));
        mem_hit    = mem_valid & mem_regwrite & (mem_wnum != 5'd0) &
                     ((mem_wnum == id_rs) | (mem_wnum == id_rt));
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;
        fwd_a_data = 32'd0;
        fwd_b_data = 32'd0;
        stall      = ex_hit | mem_hit;
    end

    assign unused_srcs = ^{ex_rs, ex_rt, ex_memread};
`endif

endmodule

// File: tb/tb_ex_writeback_fwd.sv
// Randomised and directed bench for ex_writeback_fwd; follows EXWB_FORWARD_EN like the design.
module tb_ex_writeback_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_regwrite, ex_memread, flush_mem;
    logic [31:0] ex_result, mem_rdata;
    logic [4:0]  ex_wnum, id_rs, id_rt, ex_rs, ex_rt;
    logic        wb_we, stall;
    logic [4:0]  wb_num;
    logic [31:0] wb_data, fwd_a_data, fwd_b_data;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // one in-flight instruction; d holds the value it will finally write
    typedef struct packed {
        logic        v;
        logic        rw;
        logic        ld;
        logic [4:0]  n;
        logic [31:0] d;
    } ent_t;

    ent_t hist [2];  // hist[0]: one edge past EX, hist[1]: two edges past EX

    always #5 clk = ~clk;

    ex_writeback_fwd dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_wnum(ex_wnum),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .flush_mem(flush_mem),
        .mem_rdata(mem_rdata), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .wb_we(wb_we), .wb_num(wb_num), .wb_data(wb_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data), .stall(stall)
    );

    function automatic logic [1:0] exp_sel(input logic [4:0] x);
`ifdef EXWB_FORWARD_EN
        if (x != 0 && hist[0].v && hist[0].rw && !hist[0].ld && hist[0].n == x) return 2'b01;
        if (x != 0 && hist[1].v && hist[1].rw && hist[1].n == x) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] x);
        logic [1:0] s;
        s = exp_sel(x);
        if (s == 2'b01) return hist[0].d;
        if (s == 2'b10) return hist[1].d;
        return 32'd0;
    endfunction

    function automatic logic exp_stall();
        logic ex_dep, mem_dep;
        ex_dep  = ex_valid && ex_regwrite && ex_wnum != 0 && (ex_wnum == id_rs || ex_wnum == id_rt);
        mem_dep = hist[0].v && hist[0].rw && hist[0].n != 0 && (hist[0].n == id_rs || hist[0].n == id_rt);
`ifdef EXWB_FORWARD_EN
        return ex_dep && ex_memread;
`else
        return ex_dep || mem_dep;
`endif
    endfunction

    function automatic logic exp_we();
        return hist[1].v && hist[1].rw && hist[1].n != 0;
    endfunction

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] wn,
                         input logic rw, input logic ld, input logic fl, input logic [31:0] rd,
                         input logic [4:0] irs, input logic [4:0] irt,
                         input logic [4:0] ers, input logic [4:0] ert);
        ex_valid = v; ex_result = res; ex_wnum = wn; ex_regwrite = rw; ex_memread = ld;
        flush_mem = fl; mem_rdata = rd; id_rs = irs; id_rt = irt; ex_rs = ers; ex_rt = ert;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            hist[1]   = hist[0];
            hist[1].d = hist[0].ld ? mem_rdata : hist[0].d;
            hist[0]   = '{v: ex_valid & ~flush_mem, rw: ex_regwrite, ld: ex_memread,
                          n: ex_wnum, d: ex_result};
        end else begin
            hist[0] = '0;
            hist[1] = '0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hist[0] = '0;
        hist[1] = '0;
        drive(0, 32'hDEAD_BEEF, 5'd3, 1, 0, 0, 32'h1234_5678, 5'd3, 5'd4, 5'd3, 5'd4);
        #23;
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rst_wb_we: got %b want 0", wb_we); end
        n_checks++; if (wb_num !== 5'd0) begin n_fail++; $display("FAIL rst_wb_num: got %0d want 0", wb_num); end
        n_checks++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_wb_data: got %h want 0", wb_data); end
        n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL rst_fwd_sel: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
        n_checks++; if (fwd_a_data !== 32'd0 || fwd_b_data !== 32'd0) begin n_fail++; $display("FAIL rst_fwd_data: got %h/%h want 0/0", fwd_a_data, fwd_b_data); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (wb_we !== 1'b0 || wb_data !== 32'd0) begin n_fail++; $display("FAIL post_rst_wb: got we=%b data=%h want 0/0", wb_we, wb_data); end
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL post_rst_fwd: got %b want 00", fwd_a_sel); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

`ifdef EXWB_FORWARD_EN
    task automatic test_forward();
        drain();
        drive(1, 32'h10, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h99, 5'd9, 1, 0, 0, 0, 0, 0, 5'd3, 0);
        #1;
        n_checks++; if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL mem_fwd_sel: got %b want 01", fwd_a_sel); end
        n_checks++; if (fwd_a_data !== 32'h10) begin n_fail++; $display("FAIL mem_fwd_data: got %h want 10", fwd_a_data); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mem_fwd_stall: got %b want 0", stall); end
        tick();
        drive(1, 32'hAA, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h01, 5'd6, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h02, 5'd8, 1, 0, 0, 0, 0, 0, 0, 5'd5);
        #1;
        n_checks++; if (fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL wb_fwd_sel: got %b want 10", fwd_b_sel); end
        n_checks++; if (fwd_b_data !== 32'hAA) begin n_fail++; $display("FAIL wb_fwd_data: got %h want aa", fwd_b_data); end
        tick();
        drive(1, 32'hBB, 5'd8, 1, 0, 0, 0, 0, 0, 5'd8, 5'd8);
        #1;
        n_checks++; if (fwd_a_data !== 32'h02) begin n_fail++; $display("FAIL older_fwd: got %h want 02", fwd_a_data); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd8);
        #1;
        n_checks++; if (fwd_a_sel !== 2'b01 || fwd_b_data !== 32'hBB) begin n_fail++; $display("FAIL younger_wins: got %b/%h want 01/bb", fwd_a_sel, fwd_b_data); end
        tick();
    endtask
`else
    task automatic test_no_forward();
        drain();
        drive(1, 32'h10, 5'd3, 1, 0, 0, 0, 5'd3, 0, 0, 0);
        #1;
        n_checks++; if (stall !== 1'b1 || fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL nofwd_c1: got stall=%b sel=%b want 1/00", stall, fwd_a_sel); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 0, 5'd3, 0);
        #1;
        n_checks++; if (stall !== 1'b1 || fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL nofwd_c2: got stall=%b sel=%b want 1/00", stall, fwd_a_sel); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 0, 5'd3, 0);
        #1;
        n_checks++; if (stall !== 1'b0 || fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL nofwd_c3: got stall=%b sel=%b want 0/00", stall, fwd_a_sel); end
        n_checks++; if (wb_we !== 1'b1 || wb_num !== 5'd3 || wb_data !== 32'h10) begin n_fail++; $display("FAIL nofwd_wb: got %b/%0d/%h want 1/3/10", wb_we, wb_num, wb_data); end
        tick();
    endtask
`endif

    task automatic test_load_use();
        drain();
        drive(1, 32'h0, 5'd7, 1, 1, 0, 0, 5'd7, 5'd2, 5'd1, 5'd2);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_c1: got %b want 1", stall); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h1234_5678, 5'd7, 5'd2, 0, 0);
        #1;
`ifdef EXWB_FORWARD_EN
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_stall_c2: got %b want 0", stall); end
`else
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_c2: got %b want 1", stall); end
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (wb_we !== 1'b1 || wb_num !== 5'd7) begin n_fail++; $display("FAIL ld_wb: got we=%b num=%0d want 1/7", wb_we, wb_num); end
        n_checks++; if (wb_data !== 32'h1234_5678) begin n_fail++; $display("FAIL ld_wb_data: got %h want 12345678", wb_data); end
        tick();
    endtask

    task automatic test_r0();
        drain();
        drive(1, 32'h55, 5'd0, 1, 1, 0, 32'h77, 0, 0, 0, 0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", stall); end
        tick();
        drive(1, 32'h56, 5'd0, 1, 0, 0, 32'h77, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL r0_we: got %b want 0", wb_we); end
        n_checks++; if (fwd_a_sel !== 2'b00 || fwd_a_data !== 32'd0) begin n_fail++; $display("FAIL r0_fwd: got %b/%h want 00/0", fwd_a_sel, fwd_a_data); end
        tick();
    endtask

    task automatic test_flush();
        drain();
        drive(1, 32'h44, 5'd4, 1, 0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd4, 0, 5'd4, 5'd4);
        #1;
        n_checks++; if (fwd_a_sel !== 2'b00 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_c1: got sel=%b stall=%b want 00/0", fwd_a_sel, stall); end
        tick();
        #1;
        n_checks++; if (wb_we !== 1'b0 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL flush_c2: got we=%b sel=%b want 0/00", wb_we, fwd_b_sel); end
        tick();
    endtask

    task automatic test_reset_midstream();
        drain();
        drive(1, 32'h11, 5'd1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h22, 5'd2, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd2, 5'd1);
        #1;
        n_checks++; if (wb_we !== 1'b1 || wb_num !== 5'd1) begin n_fail++; $display("FAIL pre_rst_wb: got %b/%0d want 1/1", wb_we, wb_num); end
        rst_n = 1'b0;
        hist[0] = '0;
        hist[1] = '0;
        #1;
        n_checks++; if (wb_we !== 1'b0 || wb_num !== 5'd0 || wb_data !== 32'd0) begin n_fail++; $display("FAIL midrst_wb: got %b/%0d/%h want 0/0/0", wb_we, wb_num, wb_data); end
        n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL midrst_fwd: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
        #1;
        rst_n = 1'b1;
        tick();
        #1;
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL midrst_drop: got %b want 0", wb_we); end
        tick();
    endtask

    task automatic test_random();
        logic [1:0] es;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 9) == 0), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, stall, exp_stall()); end
            es = exp_sel(ex_rs);
            n_checks++; if (fwd_a_sel !== es || fwd_a_data !== exp_data(ex_rs)) begin n_fail++; $display("FAIL rnd_fwd_a c%0d: got %b/%h want %b/%h", cyc, fwd_a_sel, fwd_a_data, es, exp_data(ex_rs)); end
            es = exp_sel(ex_rt);
            n_checks++; if (fwd_b_sel !== es || fwd_b_data !== exp_data(ex_rt)) begin n_fail++; $display("FAIL rnd_fwd_b c%0d: got %b/%h want %b/%h", cyc, fwd_b_sel, fwd_b_data, es, exp_data(ex_rt)); end
            n_checks++; if (wb_we !== exp_we()) begin n_fail++; $display("FAIL rnd_we c%0d: got %b want %b", cyc, wb_we, exp_we()); end
            if (hist[1].v) begin
                n_checks++; if (wb_num !== hist[1].n || wb_data !== hist[1].d) begin n_fail++; $display("FAIL rnd_wb c%0d: got %0d/%h want %0d/%h", cyc, wb_num, wb_data, hist[1].n, hist[1].d); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
`ifdef EXWB_FORWARD_EN
        test_forward();
`else
        test_no_forward();
`endif
        test_load_use();
        test_r0();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
